sfx_scheduler: RTL

Shares the single tone PWM generator between background music and three event sound effects (hit, start, game-over). It sits between the music controller's tone output and the tone `PWM_gen` input, and drives that generator's frequency word. Each effect is a fixed note sequence stepped on an internal tick. While an effect plays, the scheduler also tells the music path to pause.

---
 rtl/sfx_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: shares one tone PWM word between background music and
// three fixed note-sequence sound effects, with priority preemption.
module sfx_scheduler #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned TICK_HZ      = 16,
  parameter logic [31:0] SILENCE_FREQ = 32'd20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bgm_tone,
  input  logic        bgm_en,
  input  logic [2:0]  sfx_req,
  output logic [31:0] tone,
  output logic        sfx_busy,
  output logic [1:0]  sfx_id,
  output logic        bgm_pause,
  output logic        sfx_done
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TCW = $clog2(TICK_DIV);
  localparam logic [TCW-1:0] TLAST = TCW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t         r_state, w_state;
  logic [2:0]     r_pend, w_pend;
  logic [1:0]     r_step, w_step;
  logic [TCW-1:0] r_tcnt, w_tcnt;
  logic [1:0]     r_id, w_id;
  logic [31:0]    r_tone, w_tone;
  logic           r_done, w_done;

  logic       w_busy;
  logic [2:0] w_cur;
  logic [2:0] w_all;
  logic [1:0] w_top;
  logic       w_any;
  logic       w_pre;
  logic       w_tick;
  logic       w_last;
  logic       w_start;
  logic [31:0] w_bgm;

  function automatic logic [31:0] rom(input logic [1:0] id,
                                      input logic [1:0] st);
    logic [31:0] f;
    case ({id, st})
      4'b00_00: f = 32'd1320;
      4'b00_01: f = 32'd1568;
      4'b01_00: f = 32'd524;
      4'b01_01: f = 32'd660;
      4'b01_10: f = 32'd784;
      4'b01_11: f = 32'd1048;
      4'b10_00: f = 32'd392;
      4'b10_01: f = 32'd330;
      4'b10_10: f = 32'd262;
      4'b10_11: f = 32'd262;
      default:  f = SILENCE_FREQ;
    endcase
    return f;
  endfunction

  // Ids double as priorities: OVER(2) > START(1) > HIT(0).
  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_cur  = w_busy ? (3'b001 << r_id) : 3'b000;
    w_all  = r_pend | (sfx_req & ~w_cur);
    w_any  = |w_all;
    if (w_all[2])      w_top = 2'd2;
    else if (w_all[1]) w_top = 2'd1;
    else               w_top = 2'd0;
    w_pre  = w_busy && w_any && (w_top > r_id);
    w_tick = (r_tcnt == TLAST);
    w_last = (r_step == ((r_id == 2'd0) ? 2'd1 : 2'd3));
    w_bgm  = (bgm_en && bgm_tone != 32'd0) ? bgm_tone : SILENCE_FREQ;
  end

  always_comb begin
    w_state = r_state;
    w_pend  = w_all;
    w_step  = r_step;
    w_tcnt  = r_tcnt;
    w_id    = r_id;
    w_tone  = r_tone;
    w_done  = 1'b0;
    w_start = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_start = 1'b1;
        else       w_tone  = w_bgm;
      end
      S_PLAY: begin
        if (w_pre) begin
          w_start = 1'b1;
        end else if (w_tick) begin
          w_tcnt = '0;
          if (w_last) begin
            w_state = S_GAP;
            w_step  = 2'd0;
            w_tone  = SILENCE_FREQ;
          end else begin
            w_step = r_step + 2'd1;
            w_tone = rom(r_id, r_step + 2'd1);
          end
        end else begin
          w_tcnt = r_tcnt + TCW'(1);
        end
      end
      S_GAP: begin
        if (w_pre) begin
          w_start = 1'b1;
        end else if (w_tick) begin
          w_done = 1'b1;
          w_tcnt = '0;
          if (w_any) begin
            w_start = 1'b1;
          end else begin
            w_state = S_IDLE;
            w_id    = 2'd0;
            w_tone  = w_bgm;
          end
        end else begin
          w_tcnt = r_tcnt + TCW'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
        w_id    = 2'd0;
        w_tone  = SILENCE_FREQ;
      end
    endcase
    if (w_start) begin
      w_state = S_PLAY;
      w_id    = w_top;
      w_step  = 2'd0;
      w_tcnt  = '0;
      w_tone  = rom(w_top, 2'd0);
      w_pend  = w_all & ~(3'b001 << w_top);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_step  <= '0;
      r_tcnt  <= '0;
      r_id    <= '0;
      r_tone  <= SILENCE_FREQ;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pend  <= w_pend;
      r_step  <= w_step;
      r_tcnt  <= w_tcnt;
      r_id    <= w_id;
      r_tone  <= w_tone;
      r_done  <= w_done;
    end
  end

  assign tone      = r_tone;
  assign sfx_busy  = (r_state != S_IDLE);
  assign bgm_pause = sfx_busy;
  assign sfx_id    = r_id;
  assign sfx_done  = r_done;

endmodule
